message_scroller: RTL and testbench
===================================

MESSAGE_SCROLLER -- requirements
Module: message_scroller

Interface
REQ-001 The block SHALL have parameter SCROLL_DIV, default 24'd6000000, meaning clock cycles per one-position scroll step (legal range 1..2^24-1).
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning message buffer capacity in characters (fixed at 32).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have ports vdd and vss, inout, 1 bit each, present only when USE_POWER_PINS is defined.
REQ-006 The block SHALL have port wr_valid, input, 1 bit, character write request.
REQ-007 The block SHALL have port wr_ready, output, 1 bit, block can accept a character.
REQ-008 The block SHALL have port wr_char, input, 6 bits, character code (0 = space, 1..26 = A..Z, 27..36 = 0..9, 37..63 = blank).
REQ-009 The block SHALL have port wr_last, input, 1 bit, marks the final character of a message.
REQ-010 The block SHALL have port scroll_en, input, 1 bit, scroll advance enable.
REQ-011 The block SHALL have port rd_digit, input, 4 bits, digit index 0..11 requested by the downstream display multiplexer.
REQ-012 The block SHALL have port rd_segm, output, 14 bits, 14-segment pattern for rd_digit.
REQ-013 The block SHALL have port running, output, 1 bit, high in state RUN.

Function
REQ-014 The FSM SHALL have states EMPTY, LOAD, COMMIT and RUN.
REQ-015 A write SHALL be accepted on any cycle with wr_valid and wr_ready both high.
REQ-016 wr_ready SHALL be high in EMPTY, LOAD and RUN, and low in COMMIT.
REQ-017 An accepted write in EMPTY or RUN SHALL store the character at index 0, set the write count to 1 and go to LOAD.
REQ-018 An accepted write in LOAD SHALL store the character at index = count and increment count.
REQ-019 An accepted write with wr_last high, or the write that brings count to 32, SHALL go to COMMIT.
REQ-020 COMMIT SHALL last one cycle, latch msg_len = count, clear offset and the tick counter, then go to RUN.
REQ-021 In RUN with scroll_en high, the tick counter SHALL count 0..SCROLL_DIV-1; at SCROLL_DIV-1 it returns to 0 and offset increments.
REQ-022 Offset SHALL wrap from msg_len+11 to 0; the virtual ring is msg_len characters followed by 12 spaces.
REQ-023 When scroll_en is low, the tick counter and offset SHALL hold.
REQ-024 For a digit in RUN, idx = offset + rd_digit, minus (msg_len+12) if idx >= msg_len+12.
REQ-025 If idx < msg_len, the digit SHALL show the font code of buffer[idx]; otherwise it SHALL show space.
REQ-026 rd_segm SHALL be registered with exactly 1-cycle latency from rd_digit, using the offset value before any same-cycle increment.
REQ-027 rd_segm SHALL be 0 when rd_digit > 11, or when the state is EMPTY, LOAD or COMMIT.
REQ-028 The font SHALL include: space = 00000000000000; A = 11101111000000; C = 10011100000000; E = 10011110000000; I = 10010000010010; J = 01111000000000; K = 00001110001100; R = 11001111000100; T = 10000000010010.
REQ-029 All other letters and digits SHALL use the team 14-segment font table, and codes 37..63 SHALL map to 0.
REQ-030 A write accepted in RUN SHALL abort display immediately; rd_segm is 0 from the next cycle.

Reset
REQ-031 rst_n low SHALL asynchronously set state EMPTY, count 0, msg_len 0, offset 0, tick 0, rd_segm 0, running 0 and wr_ready 0.
REQ-032 Buffer contents need not be cleared on reset.
REQ-033 wr_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-034 A reset asserted during LOAD SHALL discard the partial message.

Verification (SCROLL_DIV=4)
REQ-035 Load E,R,I,C,K with wr_last on K, then scroll_en=0 and sweep rd_digit 0..11 -> digits 0..4 show E,R,I,C,K patterns, digits 5..11 show 0, and running goes high 2 cycles after the K write.
REQ-036 Same message with scroll_en=1 -> offset advances every 4 cycles; after 4 steps digit 0 shows K and digit 1 shows 0; after 17 steps offset is 0 again.
REQ-037 Write 33 characters back-to-back -> COMMIT after the 32nd, wr_ready low for 1 cycle, 33rd write accepted afterwards as index 0 of a new message, and msg_len=32 is briefly shown as running.
REQ-038 rd_digit=12..15 in RUN -> rd_segm=0; rd_digit change -> rd_segm updates exactly one cycle later.
REQ-039 Assert rst_n low mid-LOAD, asynchronously -> all outputs 0 without a clock edge; after release, state EMPTY and rd_segm=0.
REQ-040 Single-character message T -> ring length 13; T appears on digit 11 after 2 steps and wraps correctly at offset 12 -> 0.

Source files
------------

// File: rtl/message_scroller_if.sv
// Character write channel of the message scroller.
//   wr_valid : write request from the producer
//   wr_ready : scroller can accept a character this cycle
//   wr_char  : 6-bit character code (0 space, 1..26 A..Z, 27..36 0..9)
//   wr_last  : marks the final character of a message
interface message_scroller_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_char;
    logic       wr_last;

    modport master (
        output wr_valid,
        output wr_char,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_char,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/message_scroller.sv
// Scrolling 12-digit 14-segment message display.
// A message of up to DEPTH characters is written through the wr channel,
// then scrolled across the display as a ring of the message followed by
// 12 spaces. The display multiplexer asks for one digit at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   vdd, vss   : power pins (only with USE_POWER_PINS)
//   wr         : character write channel (slave side)
//   scroll_en  : allows the scroll tick counter to advance
//   rd_digit   : digit index 0..11 requested by the display multiplexer
//   rd_segm    : registered segment pattern for rd_digit (1-cycle latency)
//   running    : high while the message is being displayed
module message_scroller #(
    parameter logic [23:0] SCROLL_DIV = 24'd6000000,
    parameter int unsigned DEPTH      = 32
) (
`ifdef USE_POWER_PINS
    inout  wire                vdd,
    inout  wire                vss,
`endif
    input  logic               clk,
    input  logic               rst_n,
    message_scroller_if.slave  wr,
    input  logic               scroll_en,
    input  logic [3:0]         rd_digit,
    output logic [13:0]        rd_segm,
    output logic               running
);

    localparam int unsigned NUM_DIGITS = 12;
    localparam int unsigned CHR_W      = 6;
    localparam int unsigned SEG_W      = 14;
    localparam int unsigned TICK_W     = 24;
    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = $clog2(DEPTH + NUM_DIGITS);
    localparam int unsigned SUM_W      = CNT_W + 1;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       msg_len_q, msg_len_d;
    logic [CNT_W-1:0]       offset_q, offset_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic                   wr_ready_q;
    logic [SEG_W-1:0]       segm_d;

    logic [CHR_W-1:0]       buf_mem [DEPTH];
    logic                   buf_we;
    logic [IDX_W-1:0]       buf_waddr;

    logic                   wr_fire_c;
    logic [SUM_W-1:0]       ring_len_c;
    logic [SUM_W-1:0]       idx_raw_c;
    logic [SUM_W-1:0]       idx_c;

    // 14-segment font, bit order a b c d e f g1 g2 h j k l m n (MSB first)
    function automatic logic [SEG_W-1:0] font(input logic [CHR_W-1:0] c);
        logic [SEG_W-1:0] s;
        case (c)
            6'd0:    s = 14'b00000000000000;
            6'd1:    s = 14'b11101111000000; // A
            6'd2:    s = 14'b11110001010010; // B
            6'd3:    s = 14'b10011100000000; // C
            6'd4:    s = 14'b11110000010010; // D
            6'd5:    s = 14'b10011110000000; // E
            6'd6:    s = 14'b10001110000000; // F
            6'd7:    s = 14'b10111101000000; // G
            6'd8:    s = 14'b01101111000000; // H
            6'd9:    s = 14'b10010000010010; // I
            6'd10:   s = 14'b01111000000000; // J
            6'd11:   s = 14'b00001110001100; // K
            6'd12:   s = 14'b00011100000000; // L
            6'd13:   s = 14'b01101100101000; // M
            6'd14:   s = 14'b01101100100100; // N
            6'd15:   s = 14'b11111100000000; // O
            6'd16:   s = 14'b11001111000000; // P
            6'd17:   s = 14'b11111100000100; // Q
            6'd18:   s = 14'b11001111000100; // R
            6'd19:   s = 14'b10110111000000; // S
            6'd20:   s = 14'b10000000010010; // T
            6'd21:   s = 14'b01111100000000; // U
            6'd22:   s = 14'b00001100001001; // V
            6'd23:   s = 14'b01101100000101; // W
            6'd24:   s = 14'b00000000101101; // X
            6'd25:   s = 14'b00000000101010; // Y
            6'd26:   s = 14'b10010000001001; // Z
            6'd27:   s = 14'b11111100001001; // 0
            6'd28:   s = 14'b01100000001000; // 1
            6'd29:   s = 14'b11011011000000; // 2
            6'd30:   s = 14'b11110001000000; // 3
            6'd31:   s = 14'b01100111000000; // 4
            6'd32:   s = 14'b10010110000100; // 5
            6'd33:   s = 14'b10111111000000; // 6
            6'd34:   s = 14'b10000000001010; // 7
            6'd35:   s = 14'b11111111000000; // 8
            6'd36:   s = 14'b11110111000000; // 9
            default: s = '0;
        endcase
        return s;
    endfunction

    assign wr.wr_ready = wr_ready_q;
    assign wr_fire_c   = wr.wr_valid && wr_ready_q;
    assign ring_len_c  = SUM_W'(msg_len_q) + SUM_W'(NUM_DIGITS);

    // Ring position of the requested digit, folded back once into the ring
    assign idx_raw_c = SUM_W'(offset_q) + SUM_W'(rd_digit);
    assign idx_c     = (idx_raw_c >= ring_len_c) ? (idx_raw_c - ring_len_c) : idx_raw_c;

    // Next-state and datapath next values
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        msg_len_d = msg_len_q;
        offset_d  = offset_q;
        tick_d    = tick_q;
        buf_we    = 1'b0;
        buf_waddr = '0;
        segm_d    = '0;

        case (state_q)
            EMPTY, RUN: begin
                if (wr_fire_c) begin
                    // A new message always restarts at index 0, aborting any display
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    count_d   = CNT_W'(1);
                    state_d   = wr.wr_last ? COMMIT : LOAD;
                end else if ((state_q == RUN) && scroll_en) begin
                    if (tick_q == (SCROLL_DIV - 24'd1)) begin
                        tick_d   = '0;
                        offset_d = (SUM_W'(offset_q) == (ring_len_c - SUM_W'(1)))
                                 ? '0 : (offset_q + CNT_W'(1));
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            LOAD: begin
                if (wr_fire_c) begin
                    buf_we    = 1'b1;
                    buf_waddr = count_q[IDX_W-1:0];
                    count_d   = count_q + CNT_W'(1);
                    if (wr.wr_last || (count_q == CNT_W'(DEPTH - 1))) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                msg_len_d = count_q;
                offset_d  = '0;
                tick_d    = '0;
                state_d   = RUN;
            end
            default: state_d = EMPTY;
        endcase

        // Display lookup uses the pre-increment offset; a write in RUN blanks it
        if ((state_q == RUN) && !wr_fire_c && (rd_digit < 4'(NUM_DIGITS))
                && (idx_c < SUM_W'(msg_len_q))) begin
            segm_d = font(buf_mem[idx_c[IDX_W-1:0]]);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            msg_len_q  <= '0;
            offset_q   <= '0;
            tick_q     <= '0;
            rd_segm    <= '0;
            running    <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            msg_len_q  <= msg_len_d;
            offset_q   <= offset_d;
            tick_q     <= tick_d;
            rd_segm    <= segm_d;
            running    <= (state_d == RUN);
            wr_ready_q <= (state_d != COMMIT);
        end
    end

    // Message buffer; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[buf_waddr] <= wr.wr_char;
        end
    end

endmodule

// File: tb/tb_message_scroller.sv
// Self-checking bench for message_scroller (SCROLL_DIV = 4).
// Display reads are queued with their expected pattern; a monitor pops and
// compares one cycle later. Control outputs are checked directly.
module tb_message_scroller;

    localparam logic [13:0] SEG_SP = 14'b00000000000000;
    localparam logic [13:0] SEG_C  = 14'b10011100000000;
    localparam logic [13:0] SEG_E  = 14'b10011110000000;
    localparam logic [13:0] SEG_I  = 14'b10010000010010;
    localparam logic [13:0] SEG_K  = 14'b00001110001100;
    localparam logic [13:0] SEG_R  = 14'b11001111000100;
    localparam logic [13:0] SEG_T  = 14'b10000000010010;

    localparam logic [5:0] CH_A = 6'd1;
    localparam logic [5:0] CH_C = 6'd3;
    localparam logic [5:0] CH_E = 6'd5;
    localparam logic [5:0] CH_I = 6'd9;
    localparam logic [5:0] CH_K = 6'd11;
    localparam logic [5:0] CH_R = 6'd18;
    localparam logic [5:0] CH_T = 6'd20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scroll_en;
    logic [3:0]  rd_digit;
    logic [13:0] rd_segm;
    logic        running;

    logic        rd_req = 1'b0;
    logic        req_q  = 1'b0;
    logic [13:0] exp_q [$];
    string       name_q [$];

    int checks   = 0;
    int failures = 0;

    message_scroller_if wif ();

    message_scroller #(
        .SCROLL_DIV (24'd4),
        .DEPTH      (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wif),
        .scroll_en (scroll_en),
        .rd_digit  (rd_digit),
        .rd_segm   (rd_segm),
        .running   (running)
    );

    always #5 clk = ~clk;

    // Marks which cycles carry a display read whose result is due
    always @(posedge clk) req_q <= rd_req;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (req_q) begin
            logic [13:0] e;
            string       n;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow: rd_segm=%b with no expected entry", rd_segm);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rd_segm !== e) begin
                    failures++;
                    $display("FAIL %s: rd_segm=%b expected=%b", n, rd_segm, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one display read; result is checked by the monitor next cycle
    task automatic rd(input logic [3:0] d, input logic [13:0] exp, input string name);
        rd_digit = d;
        rd_req   = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    // One write, waiting (bounded) for wr_ready
    task automatic wr(input logic [5:0] c, input logic last);
        int n;
        wif.wr_valid = 1'b1;
        wif.wr_char  = c;
        wif.wr_last  = last;
        n = 0;
        while ((wif.wr_ready !== 1'b1) && (n < 20)) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL wr_timeout: wr_ready=%b expected=1", wif.wr_ready);
        end
        @(posedge clk); #1;
        wif.wr_valid = 1'b0;
        wif.wr_last  = 1'b0;
    endtask

    // Enable scrolling for exactly n clock edges
    task automatic steps(input int n);
        scroll_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        scroll_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        scroll_en    = 1'b0;
        rd_digit     = 4'd0;
        wif.wr_valid = 1'b0;
        wif.wr_char  = 6'd0;
        wif.wr_last  = 1'b0;

        // Reset state
        #12;
        chk("rst_wr_ready", 14'(wif.wr_ready), 14'd0);
        chk("rst_running",  14'(running),      14'd0);
        chk("rst_segm",     rd_segm,           SEG_SP);
        rst_n = 1'b1;
        #1;
        chk("rel_wr_ready_before_edge", 14'(wif.wr_ready), 14'd0);
        @(posedge clk); #1;
        chk("rel_wr_ready_after_edge", 14'(wif.wr_ready), 14'd1);

        // ERICK, static sweep
        wr(CH_E, 1'b0);
        wr(CH_R, 1'b0);
        wr(CH_I, 1'b0);
        wr(CH_C, 1'b0);
        wr(CH_K, 1'b1);
        chk("commit_running",  14'(running),      14'd0);
        chk("commit_wr_ready", 14'(wif.wr_ready), 14'd0);
        @(posedge clk); #1;
        chk("run_running",  14'(running),      14'd1);
        chk("run_wr_ready", 14'(wif.wr_ready), 14'd1);
        rd(4'd0,  SEG_E,  "sweep_d0");
        rd(4'd1,  SEG_R,  "sweep_d1");
        rd(4'd2,  SEG_I,  "sweep_d2");
        rd(4'd3,  SEG_C,  "sweep_d3");
        rd(4'd4,  SEG_K,  "sweep_d4");
        for (int d = 5; d < 12; d++) rd(4'(d), SEG_SP, "sweep_blank");
        for (int d = 12; d < 16; d++) rd(4'(d), SEG_SP, "digit_out_of_range");

        // Scrolling: ring of 17 positions
        steps(3);
        rd(4'd0, SEG_E,  "tick3_no_step_d0");
        steps(1);
        rd(4'd0, SEG_R,  "step1_d0");
        rd(4'd3, SEG_K,  "step1_d3");
        rd(4'd4, SEG_SP, "step1_d4");
        steps(12);
        rd(4'd0, SEG_K,  "step4_d0");
        rd(4'd1, SEG_SP, "step4_d1");
        steps(48);
        rd(4'd0,  SEG_SP, "step16_d0");
        rd(4'd1,  SEG_E,  "step16_d1");
        rd(4'd2,  SEG_R,  "step16_d2");
        rd(4'd11, SEG_SP, "step16_d11");
        steps(4);
        rd(4'd0, SEG_E,  "step17_d0");
        rd(4'd4, SEG_K,  "step17_d4");
        rd(4'd5, SEG_SP, "step17_d5");

        // Write in RUN aborts the display the next cycle (first of a 33-char burst)
        wif.wr_valid = 1'b1;
        wif.wr_char  = CH_A;
        wif.wr_last  = 1'b0;
        rd_digit     = 4'd0;
        rd_req       = 1'b1;
        exp_q.push_back(SEG_SP);
        name_q.push_back("abort_on_write");
        @(posedge clk); #1;
        rd_req       = 1'b0;
        wif.wr_valid = 1'b0;
        chk("abort_running", 14'(running), 14'd0);
        for (int i = 1; i < 32; i++) wr(6'((i % 36) + 1), 1'b0);
        chk("full_commit_wr_ready", 14'(wif.wr_ready), 14'd0);
        chk("full_commit_running",  14'(running),      14'd0);

        // 33rd write: stalled by COMMIT, then starts a new one-char message T
        wif.wr_valid = 1'b1;
        wif.wr_char  = CH_T;
        wif.wr_last  = 1'b1;
        @(posedge clk); #1;
        chk("full_run_wr_ready", 14'(wif.wr_ready), 14'd1);
        chk("full_run_running",  14'(running),      14'd1);
        @(posedge clk); #1;
        wif.wr_valid = 1'b0;
        wif.wr_last  = 1'b0;
        chk("t_commit_wr_ready", 14'(wif.wr_ready), 14'd0);
        chk("t_commit_running",  14'(running),      14'd0);
        @(posedge clk); #1;
        chk("t_run_running", 14'(running), 14'd1);

        // Single T: ring of 13 positions
        rd(4'd0,  SEG_T,  "t_off0_d0");
        rd(4'd1,  SEG_SP, "t_off0_d1");
        rd(4'd12, SEG_SP, "t_off0_d12");
        steps(8);
        rd(4'd11, SEG_T,  "t_off2_d11");
        rd(4'd10, SEG_SP, "t_off2_d10");
        rd(4'd0,  SEG_SP, "t_off2_d0");
        steps(40);
        rd(4'd0,  SEG_SP, "t_off12_d0");
        rd(4'd1,  SEG_T,  "t_off12_d1");
        steps(4);
        rd(4'd11, SEG_SP, "t_wrap_d11");
        rd(4'd0,  SEG_T,  "t_wrap_d0");

        // Asynchronous reset while displaying
        @(posedge clk); #1;
        chk("pre_reset_segm", rd_segm, SEG_T);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_run_segm",     rd_segm,           SEG_SP);
        chk("async_rst_run_running",  14'(running),      14'd0);
        chk("async_rst_run_wr_ready", 14'(wif.wr_ready), 14'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_wr_ready", 14'(wif.wr_ready), 14'd1);
        chk("post_rst_segm",     rd_segm,           SEG_SP);

        // Asynchronous reset mid-LOAD discards the partial message
        wr(CH_E, 1'b0);
        wr(CH_R, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_load_wr_ready", 14'(wif.wr_ready), 14'd0);
        chk("async_rst_load_running",  14'(running),      14'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("load_rst_wr_ready", 14'(wif.wr_ready), 14'd1);
        wr(CH_C, 1'b1);
        @(posedge clk); #1;
        chk("c_run_running", 14'(running), 14'd1);
        rd(4'd0, SEG_C,  "c_d0");
        rd(4'd1, SEG_SP, "c_d1");
        rd(4'd2, SEG_SP, "c_d2");

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: entries=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
